// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: two register-file write ports shared by two ALUs (always win) and
// three one-entry slow-unit buffers (mul, ldst, branch) drained round-robin into free ports.
module core_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_a_valid,
  input  logic [3:0]  alu_a_rd,
  input  logic [31:0] alu_a_value,
  input  logic        alu_b_valid,
  input  logic [3:0]  alu_b_rd,
  input  logic [31:0] alu_b_value,
  input  logic        mul_valid,
  input  logic [3:0]  mul_rd,
  input  logic [31:0] mul_value,
  input  logic        ldst_valid,
  input  logic [3:0]  ldst_rd,
  input  logic [31:0] ldst_value,
  input  logic        branch_valid,
  input  logic [3:0]  branch_rd,
  input  logic [31:0] branch_value,
  output logic        mul_ready,
  output logic        ldst_ready,
  output logic        wb_stall_branch,
  output logic        wr_en_a,
  output logic        wr_en_b,
  output logic [3:0]  wr_r_a,
  output logic [3:0]  wr_r_b,
  output logic [31:0] wr_value_a,
  output logic [31:0] wr_value_b,
  output logic [15:0] pending_mask
);

  logic [2:0]        full_q, full_d;
  logic [2:0][3:0]   rd_q, rd_d;
  logic [2:0][31:0]  val_q, val_d;
  logic [1:0]        rr_q, rr_d;

  logic              wr_en_a_q, wr_en_b_q;
  logic [3:0]        wr_r_a_q, wr_r_b_q;
  logic [31:0]       wr_value_a_q, wr_value_b_q;

  logic [2:0]        drain;
  logic              buf_a, buf_b, free_a, free_b;
  logic [1:0]        src_a, src_b, scan_idx, last_idx;
  logic [2:0]        scan_sum;

  logic              wa_en, wb_en;
  logic [3:0]        wa_rd, wb_rd;
  logic [31:0]       wa_val, wb_val;

  logic [2:0]        in_valid, in_ready;
  logic [2:0][3:0]   in_rd;
  logic [2:0][31:0]  in_val;

  function automatic logic [1:0] mod3(input logic [2:0] s);
    mod3 = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Scan buffers from rr; first hit takes the lowest free port, second hit the other.
  always_comb begin
    drain    = '0;
    buf_a    = 1'b0;
    buf_b    = 1'b0;
    src_a    = 2'd0;
    src_b    = 2'd0;
    last_idx = rr_q;
    scan_sum = '0;
    scan_idx = '0;
    free_a   = !alu_a_valid;
    free_b   = !alu_b_valid;
    for (int k = 0; k < 3; k++) begin
      scan_sum = {1'b0, rr_q} + 3'(k);
      scan_idx = mod3(scan_sum);
      if (full_q[scan_idx]) begin
        if (free_a) begin
          free_a           = 1'b0;
          buf_a            = 1'b1;
          src_a            = scan_idx;
          drain[scan_idx]  = 1'b1;
          last_idx         = scan_idx;
        end else if (free_b) begin
          free_b           = 1'b0;
          buf_b            = 1'b1;
          src_b            = scan_idx;
          drain[scan_idx]  = 1'b1;
          last_idx         = scan_idx;
        end
      end
    end
    rr_d = (|drain) ? mod3({1'b0, last_idx} + 3'd1) : rr_q;
  end

  // Port muxing; on a same-rd clash port B wins, the port A source still counts as consumed.
  always_comb begin
    wa_en  = alu_a_valid | buf_a;
    wb_en  = alu_b_valid | buf_b;
    wa_rd  = alu_a_valid ? alu_a_rd    : rd_q[src_a];
    wa_val = alu_a_valid ? alu_a_value : val_q[src_a];
    wb_rd  = alu_b_valid ? alu_b_rd    : rd_q[src_b];
    wb_val = alu_b_valid ? alu_b_value : val_q[src_b];
    if (wa_en && wb_en && (wa_rd == wb_rd)) wa_en = 1'b0;
  end

  assign mul_ready       = !full_q[0] || drain[0];
  assign ldst_ready      = !full_q[1] || drain[1];
  assign wb_stall_branch = full_q[2] && !drain[2];

  assign in_valid = {branch_valid, ldst_valid, mul_valid};
  assign in_ready = {!wb_stall_branch, ldst_ready, mul_ready};
  assign in_rd    = {branch_rd, ldst_rd, mul_rd};
  assign in_val   = {branch_value, ldst_value, mul_value};

  always_comb begin
    full_d = full_q;
    rd_d   = rd_q;
    val_d  = val_q;
    for (int i = 0; i < 3; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        full_d[i] = 1'b1;
        rd_d[i]   = in_rd[i];
        val_d[i]  = in_val[i];
      end else if (drain[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < 3; i++) begin
      if (full_q[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= '0;
      rr_q         <= 2'd0;
      wr_en_a_q    <= 1'b0;
      wr_en_b_q    <= 1'b0;
      wr_r_a_q     <= '0;
      wr_r_b_q     <= '0;
      wr_value_a_q <= '0;
      wr_value_b_q <= '0;
    end else begin
      full_q       <= full_d;
      rr_q         <= rr_d;
      wr_en_a_q    <= wa_en;
      wr_en_b_q    <= wb_en;
      wr_r_a_q     <= wa_rd;
      wr_r_b_q     <= wb_rd;
      wr_value_a_q <= wa_val;
      wr_value_b_q <= wb_val;
    end
  end

  // Buffer payload is only meaningful while full, so it carries no reset.
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    val_q <= val_d;
  end

  assign wr_en_a    = wr_en_a_q;
  assign wr_en_b    = wr_en_b_q;
  assign wr_r_a     = wr_r_a_q;
  assign wr_r_b     = wr_r_b_q;
  assign wr_value_a = wr_value_a_q;
  assign wr_value_b = wr_value_b_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: cycle table of inputs with hand-computed outputs,
// plus a mid-operation asynchronous reset sequence.
module tb_core_wb_arbiter;

  logic        clk, rst_n;
  logic        alu_a_valid, alu_b_valid, mul_valid, ldst_valid, branch_valid;
  logic [3:0]  alu_a_rd, alu_b_rd, mul_rd, ldst_rd, branch_rd;
  logic [31:0] alu_a_value, alu_b_value, mul_value, ldst_value, branch_value;
  logic        mul_ready, ldst_ready, wb_stall_branch;
  logic        wr_en_a, wr_en_b;
  logic [3:0]  wr_r_a, wr_r_b;
  logic [31:0] wr_value_a, wr_value_b;
  logic [15:0] pending_mask;

  core_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_a_valid(alu_a_valid), .alu_a_rd(alu_a_rd), .alu_a_value(alu_a_value),
    .alu_b_valid(alu_b_valid), .alu_b_rd(alu_b_rd), .alu_b_value(alu_b_value),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_value(mul_value),
    .ldst_valid(ldst_valid), .ldst_rd(ldst_rd), .ldst_value(ldst_value),
    .branch_valid(branch_valid), .branch_rd(branch_rd), .branch_value(branch_value),
    .mul_ready(mul_ready), .ldst_ready(ldst_ready), .wb_stall_branch(wb_stall_branch),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_r_a(wr_r_a), .wr_r_b(wr_r_b),
    .wr_value_a(wr_value_a), .wr_value_b(wr_value_b), .pending_mask(pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [3:0] ard; logic [31:0] aval;
    logic bv; logic [3:0] brd; logic [31:0] bval;
    logic mv; logic [3:0] mrd; logic [31:0] mval;
    logic lv; logic [3:0] lrd; logic [31:0] lval;
    logic rv; logic [3:0] rrd; logic [31:0] rval;
    logic e_mr; logic e_lr; logic e_st; logic [15:0] e_pm;
    logic e_ea; logic [3:0] e_ra; logic [31:0] e_va;
    logic e_eb; logic [3:0] e_rb; logic [31:0] e_vb;
  } vec_t;

  vec_t vecs[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic add(
    input logic av, input logic [3:0] ard, input logic [31:0] aval,
    input logic bv, input logic [3:0] brd, input logic [31:0] bval,
    input logic mv, input logic [3:0] mrd, input logic [31:0] mval,
    input logic lv, input logic [3:0] lrd, input logic [31:0] lval,
    input logic rv, input logic [3:0] rrd, input logic [31:0] rval,
    input logic e_mr, input logic e_lr, input logic e_st, input logic [15:0] e_pm,
    input logic e_ea, input logic [3:0] e_ra, input logic [31:0] e_va,
    input logic e_eb, input logic [3:0] e_rb, input logic [31:0] e_vb);
    vec_t v;
    v = '{av, ard, aval, bv, brd, bval, mv, mrd, mval, lv, lrd, lval, rv, rrd, rval,
          e_mr, e_lr, e_st, e_pm, e_ea, e_ra, e_va, e_eb, e_rb, e_vb};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_a_valid  = v.av; alu_a_rd  = v.ard; alu_a_value  = v.aval;
    alu_b_valid  = v.bv; alu_b_rd  = v.brd; alu_b_value  = v.bval;
    mul_valid    = v.mv; mul_rd    = v.mrd; mul_value    = v.mval;
    ldst_valid   = v.lv; ldst_rd   = v.lrd; ldst_value   = v.lval;
    branch_valid = v.rv; branch_rd = v.rrd; branch_value = v.rval;
  endtask

  initial begin
    vec_t idle;
    // Both ALUs in the same cycle
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 0,0,0,        0,0,0);
    add(1,3,'h11,    1,5,'h22,    0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 0,0,0,        0,0,0);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 1,3,'h11,     1,5,'h22);
    // Fill all three buffers, ALUs hold both ports for two more cycles, then drain
    add(1,1,'hA1,    1,2,'hB2,    1,8,'h100,    1,9,'h200,    1,10,'h300,   1,1,0,16'h0000, 0,0,0,        0,0,0);
    add(1,1,'hA3,    1,2,'hB4,    0,0,0,        0,0,0,        0,0,0,        0,0,1,16'h0700, 1,1,'hA1,     1,2,'hB2);
    add(1,1,'hA5,    1,2,'hB6,    0,0,0,        0,0,0,        0,0,0,        0,0,1,16'h0700, 1,1,'hA3,     1,2,'hB4);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,1,16'h0700, 1,1,'hA5,     1,2,'hB6);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0400, 1,8,'h100,    1,9,'h200);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 1,10,'h300,   0,0,0);
    // Single mul result, 2-cycle latency
    add(0,0,0,       0,0,0,       1,7,'hDEAD,   0,0,0,        0,0,0,        1,1,0,16'h0000, 0,0,0,        0,0,0);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0080, 0,0,0,        0,0,0);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 1,7,'hDEAD,   0,0,0);
    // ALU A busy 6 cycles, mul and ldst streaming; rr starts at 1
    add(1,1,'hC1,    0,0,0,       1,11,'h1000,  1,12,'h2000,  0,0,0,        1,1,0,16'h0000, 0,0,0,        0,0,0);
    add(1,1,'hC2,    0,0,0,       1,11,'h1001,  1,12,'h2001,  0,0,0,        0,1,0,16'h1800, 1,1,'hC1,     0,0,0);
    add(1,1,'hC3,    0,0,0,       1,11,'h1001,  1,12,'h2002,  0,0,0,        1,0,0,16'h1800, 1,1,'hC2,     1,12,'h2000);
    add(1,1,'hC4,    0,0,0,       1,11,'h1002,  1,12,'h2002,  0,0,0,        0,1,0,16'h1800, 1,1,'hC3,     1,11,'h1000);
    add(1,1,'hC5,    0,0,0,       1,11,'h1002,  1,12,'h2003,  0,0,0,        1,0,0,16'h1800, 1,1,'hC4,     1,12,'h2001);
    add(1,1,'hC6,    0,0,0,       1,11,'h1003,  1,12,'h2003,  0,0,0,        0,1,0,16'h1800, 1,1,'hC5,     1,11,'h1001);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h1800, 1,1,'hC6,     1,12,'h2002);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 1,11,'h1002,  1,12,'h2003);
    // Same destination on both ALUs: port B wins
    add(1,4,'h1,     1,4,'h2,     0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 0,0,0,        0,0,0);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 0,0,0,        1,4,'h2);
    add(0,0,0,       0,0,0,       0,0,0,        0,0,0,        0,0,0,        1,1,0,16'h0000, 0,0,0,        0,0,0);

    idle = vecs[0];
    drive(idle);
    rst_n = 1'b0;
    #1;
    check("rst_mul_ready", 32'(mul_ready), 32'd1);
    check("rst_ldst_ready", 32'(ldst_ready), 32'd1);
    check("rst_stall", 32'(wb_stall_branch), 32'd0);
    check("rst_pending", 32'(pending_mask), 32'd0);
    check("rst_wr_en", {30'd0, wr_en_a, wr_en_b}, 32'd0);
    check("rst_wr_r", {24'd0, wr_r_a, wr_r_b}, 32'd0);
    check("rst_wr_val_a", wr_value_a, 32'd0);
    check("rst_wr_val_b", wr_value_b, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("r%0d_mul_ready", i), 32'(mul_ready), 32'(vecs[i].e_mr));
      check($sformatf("r%0d_ldst_ready", i), 32'(ldst_ready), 32'(vecs[i].e_lr));
      check($sformatf("r%0d_stall_branch", i), 32'(wb_stall_branch), 32'(vecs[i].e_st));
      check($sformatf("r%0d_pending", i), 32'(pending_mask), 32'(vecs[i].e_pm));
      check($sformatf("r%0d_wr_en_a", i), 32'(wr_en_a), 32'(vecs[i].e_ea));
      check($sformatf("r%0d_wr_en_b", i), 32'(wr_en_b), 32'(vecs[i].e_eb));
      if (vecs[i].e_ea) begin
        check($sformatf("r%0d_wr_r_a", i), 32'(wr_r_a), 32'(vecs[i].e_ra));
        check($sformatf("r%0d_wr_value_a", i), wr_value_a, vecs[i].e_va);
      end
      if (vecs[i].e_eb) begin
        check($sformatf("r%0d_wr_r_b", i), 32'(wr_r_b), 32'(vecs[i].e_rb));
        check($sformatf("r%0d_wr_value_b", i), wr_value_b, vecs[i].e_vb);
      end
      @(negedge clk);
    end

    // ldst buffered behind busy ALUs, then asynchronous reset mid-operation
    drive(idle);
    alu_a_valid = 1'b1; alu_a_rd = 4'd1; alu_a_value = 32'h5;
    alu_b_valid = 1'b1; alu_b_rd = 4'd2; alu_b_value = 32'h6;
    ldst_valid  = 1'b1; ldst_rd  = 4'd6; ldst_value  = 32'h55;
    @(posedge clk);
    #1;
    ldst_valid = 1'b0;
    #1;
    check("pre_rst_ldst_ready", 32'(ldst_ready), 32'd0);
    check("pre_rst_pending", 32'(pending_mask), 32'h0040);
    check("pre_rst_wr_en_a", 32'(wr_en_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ldst_ready", 32'(ldst_ready), 32'd1);
    check("async_rst_pending", 32'(pending_mask), 32'd0);
    check("async_rst_wr_en", {30'd0, wr_en_a, wr_en_b}, 32'd0);
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_rst%0d_wr_en", c), {30'd0, wr_en_a, wr_en_b}, 32'd0);
      check($sformatf("post_rst%0d_pending", c), 32'(pending_mask), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
# core_wb_arbiter

Writeback arbiter placed between the execution units and the register-file write ports. Arbitrates the two register-file write ports among the two single-cycle ALUs and the three multi-cycle units (mul, ldst, branch link). ALUs always win. Multi-cycle results are parked in one-entry buffers and drained round-robin into leftover ports. Exports per-unit backpressure and a pending-write mask for dispatch hazard checks.

## Interface

- No parameters; widths are the core's `word` (32), `reg_num` (4) and `hword` (16).
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_a_valid, alu_b_valid  in  1  ALU result present this cycle; ALUs cannot be stalled
- alu_a_rd, alu_b_rd  in  reg_num  ALU destination register
- alu_a_value, alu_b_value  in  word  ALU result
- mul_valid, ldst_valid, branch_valid  in  1  slow-unit result offered
- mul_rd, ldst_rd, branch_rd  in  reg_num  slow-unit destination
- mul_value, ldst_value, branch_value  in  word  slow-unit result
- mul_ready, ldst_ready  out  1  result accepted at the next edge when valid
- wb_stall_branch  out  1  branch unit must hold its link result (inverse of branch ready)
- wr_en_a, wr_en_b  out  1  register-file write enables (registered)
- wr_r_a, wr_r_b  out  reg_num  write addresses (registered)
- wr_value_a, wr_value_b  out  word  write data (registered)
- pending_mask  out  hword  one bit per register with a buffered, unwritten result

## Operation

- State:
  - Three buffers {full, rd, value}, one each for mul (index 0), ldst (1) and branch (2).
  - Round-robin pointer `rr`, 2 bits, legal values 0–2.
- Port allocation each cycle, combinational from current state and ALU inputs:
  - Port A goes to ALU A if alu_a_valid. Port B goes to ALU B if alu_b_valid.
  - Each unclaimed port goes to a full buffer, scanning indices rr, rr+1, rr+2 mod 3.
  - The first found buffer fills the lowest free port (A before B). The second found buffer fills the remaining port.
  - A granted buffer sets drain_x.
- Pointer update: if at least one buffer drains, rr takes (index of the last drained buffer + 1) mod 3. Otherwise rr holds.
- Ready:
  - x_ready = !full_x || drain_x, for mul and ldst.
  - wb_stall_branch = full_branch && !drain_branch.
  - These outputs must not depend on any slow-unit valid (no combinational loop).
- Buffer update at the edge:
  - If x_valid && x_ready, the buffer loads {1, rd, value}.
  - Else if drain_x, full_x is cleared.
  - Else the buffer holds.
- Same-rd conflict between the two ports in one cycle:
  - Port B wins and wr_en_a is forced to 0 for that cycle.
  - The source feeding port A is still treated as consumed (buffer drains).
  - Dispatch guarantees no WAW against buffered results; this rule covers ALU A vs ALU B.
- pending_mask = OR over full buffers of onehot(rd_x). It is combinational from registered state.

## Timing

- Reset values:
  - All full flags, wr_en_a, wr_en_b, wr_r_*, wr_value_* are 0; rr = 0.
  - Hence mul_ready = ldst_ready = 1, wb_stall_branch = 0, pending_mask = 0.
- ALU result: written one cycle after its valid cycle (wr_* registered).
- Slow result, no contention:
  - Captured at edge N, drained in cycle N+1, visible on wr_* after edge N+2.
  - Minimum latency is 2 cycles.
- Throughput per slow unit is 1 result per cycle when it is drained every cycle (capture and drain in the same edge).
- Both ALUs valid:
  - No buffer drains; all slow buffers hold.
  - Units with full buffers see ready low or wb_stall_branch high.
- Starvation bound: with at least one free port per cycle, any full buffer drains within 3 cycles.
- Reset mid-operation: buffered results are discarded; wr_en_* deassert immediately (async).

## Test plan

- Reset, then alu_a rd=3 value=0x11 and alu_b rd=5 value=0x22 in the same cycle.
  - Next cycle: wr_en_a=1 r=3 0x11, wr_en_b=1 r=5 0x22.
  - pending_mask=0.
- mul_valid rd=7 value=0xDEAD, no ALU traffic.
  - After the capture edge: pending_mask=0x0080.
  - One cycle later: wr_en_a=1 r=7 0xDEAD, pending_mask=0.
  - Total latency 2 cycles.
- All three slow buffers full, both ALUs valid for 2 cycles.
  - mul_ready=0, ldst_ready=0, wb_stall_branch=1 during those cycles; no slow writes.
  - Then ALUs go idle with rr=0: drains mul (port A) and ldst (port B); rr becomes 2.
  - Next cycle: branch drains.
- Only alu_a valid for 6 cycles while mul and ldst each present a new result every cycle.
  - Port B alternates mul, ldst, mul, …; rr alternates.
  - Neither unit waits more than 2 cycles.
- alu_a rd=4 value=0x1 and alu_b rd=4 value=0x2 together.
  - Next cycle: wr_en_a=0, wr_en_b=1 r=4 0x2.
- Assert rst_n low while the ldst buffer is full.
  - Immediately: ldst_ready=1, pending_mask=0.
  - After release: no ldst write occurs.
